modexp_sched: RTL and testbench

Round-robin scheduler that shares one `modexp` engine between `NREQ` requesters. It accepts one request at a time over valid/ready, latches the operands, and pulses the engine's `start`. It then waits for `done`, guards the wait with a watchdog, and returns the tagged result over a valid/ready response port. It sits directly in front of the `modexp` instance in the RSA path and drives all of that engine's control and operand inputs.

---
 rtl/modexp_pkg.sv | 16 +
 rtl/modexp_rr_pick.sv | 30 +++
 rtl/modexp_sched.sv | 131 +++++++++++++
 tb/tb_modexp_sched.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/modexp_pkg.sv
// Shared types and default sizing for the modexp request scheduler.
package modexp_pkg;

  localparam int unsigned DEF_NREQ    = 4;
  localparam int unsigned DEF_W       = 4096;
  localparam int unsigned DEF_TIMEOUT = 65536;
  localparam int unsigned IDW         = $clog2(DEF_NREQ);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    BUSY,
    RESP
  } sched_state_t;

endpackage

// File: rtl/modexp_rr_pick.sv
// Combinational round-robin picker: first valid requester after last_grant, wrapping.
module modexp_rr_pick
  import modexp_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned GW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [GW-1:0]   last_grant,
  output logic            any,
  output logic [GW-1:0]   grant_idx,
  output logic [NREQ-1:0] grant
);

  always_comb begin
    int unsigned w_idx;
    any       = 1'b0;
    grant_idx = '0;
    w_idx     = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_idx = (int'(last_grant) + k) % NREQ;
      if (!any && req_valid[w_idx]) begin
        any       = 1'b1;
        grant_idx = GW'(w_idx);
      end
    end
    grant = any ? (NREQ'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/modexp_sched.sv
// Round-robin front end sharing one modexp engine between NREQ requesters,
// with a stall-aware watchdog on the engine's busy phase.
module modexp_sched
  import modexp_pkg::*;
#(
  parameter int unsigned NREQ    = DEF_NREQ,
  parameter int unsigned W       = DEF_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*W-1:0]        req_key,
  input  logic [NREQ*W-1:0]        req_exp,
  input  logic [NREQ*W-1:0]        req_mod,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [W-1:0]             rsp_data,
  output logic                     rsp_err,
  output logic                     eng_start,
  output logic [W-1:0]             eng_key,
  output logic [W-1:0]             eng_exp,
  output logic [W-1:0]             eng_mod,
  output logic                     eng_stall,
  output logic                     eng_abort,
  input  logic                     eng_done,
  input  logic                     eng_valid,
  input  logic [W-1:0]             eng_result
);

  localparam int unsigned GW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(TIMEOUT) + 1;

  sched_state_t    r_state;
  logic [GW-1:0]   r_last;
  logic [GW-1:0]   r_id;
  logic [CW-1:0]   r_cnt;
  logic            w_any;
  logic [GW-1:0]   w_gidx;
  logic [NREQ-1:0] w_grant;
  logic            w_take;

  modexp_rr_pick #(
    .NREQ (NREQ),
    .GW   (GW)
  ) u_pick (
    .req_valid  (req_valid),
    .last_grant (r_last),
    .any        (w_any),
    .grant_idx  (w_gidx),
    .grant      (w_grant)
  );

  assign eng_stall = stall;

  // Gated by rst so nothing is accepted while the block is held in reset.
  always_comb begin
    w_take    = rst && (r_state == IDLE) && !stall && w_any;
    req_ready = w_take ? w_grant : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_last    <= GW'(NREQ - 1);
      r_id      <= '0;
      r_cnt     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      eng_start <= 1'b0;
      eng_abort <= 1'b0;
      eng_key   <= '0;
      eng_exp   <= '0;
      eng_mod   <= '0;
    end else begin
      eng_start <= 1'b0;
      eng_abort <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_take) begin
            eng_key   <= req_key[w_gidx*W +: W];
            eng_exp   <= req_exp[w_gidx*W +: W];
            eng_mod   <= req_mod[w_gidx*W +: W];
            r_id      <= w_gidx;
            r_last    <= w_gidx;
            eng_start <= 1'b1;
            r_state   <= LAUNCH;
          end
        end
        LAUNCH: begin
          r_cnt   <= '0;
          r_state <= BUSY;
        end
        BUSY: begin
          // done takes priority over a watchdog expiry in the same cycle
          if (eng_done) begin
            rsp_valid <= 1'b1;
            rsp_id    <= r_id;
            rsp_data  <= eng_valid ? eng_result : '0;
            rsp_err   <= !eng_valid;
            r_state   <= RESP;
          end else if (!stall) begin
            if (r_cnt == CW'(TIMEOUT - 1)) begin
              eng_abort <= 1'b1;
              rsp_valid <= 1'b1;
              rsp_id    <= r_id;
              rsp_data  <= '0;
              rsp_err   <= 1'b1;
              r_state   <= RESP;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_sched.sv
// Self-checking bench for modexp_sched: directed vector table, hand-written
// reset/stall sequences, and randomized transactions against a behavioural model.
module tb_modexp_sched;

  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int TMO  = 16;

  logic            clk = 1'b0;
  logic            rst, stall, rsp_ready, eng_done, eng_valid;
  logic [3:0]      req_valid, req_ready;
  logic [63:0]     req_key, req_exp, req_mod;
  logic            rsp_valid, rsp_err, eng_start, eng_stall, eng_abort;
  logic [1:0]      rsp_id;
  logic [15:0]     rsp_data, eng_key, eng_exp, eng_mod, eng_result;

  logic [15:0] key[4];
  logic [15:0] ex[4];
  logic [15:0] md[4];

  int total = 0;
  int bad   = 0;
  int last;

  modexp_sched #(
    .NREQ    (NREQ),
    .W       (W),
    .TIMEOUT (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_key    (req_key),
    .req_exp    (req_exp),
    .req_mod    (req_mod),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .eng_start  (eng_start),
    .eng_key    (eng_key),
    .eng_exp    (eng_exp),
    .eng_mod    (eng_mod),
    .eng_stall  (eng_stall),
    .eng_abort  (eng_abort),
    .eng_done   (eng_done),
    .eng_valid  (eng_valid),
    .eng_result (eng_result)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mexp(input logic [15:0] b, input logic [15:0] e, input logic [15:0] m);
    longint unsigned r, x, mm;
    mm = longint'(m);
    r  = 1 % mm;
    x  = longint'(b) % mm;
    for (int i = 0; i < 16; i++) begin
      if (e[i]) r = (r * x) % mm;
      x = (x * x) % mm;
    end
    return 16'(r);
  endfunction

  function automatic int pick(input logic [3:0] reqv, input int lg);
    for (int i = 1; i <= NREQ; i++) begin
      if (reqv[(lg + i) % NREQ]) return (lg + i) % NREQ;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: grant, launch, engine behaviour, response, handshake.
  task automatic do_txn(input logic [3:0] reqv, input int g, input int lat, input bit ok,
                        input int hold, input int sn, input bit exp_err);
    logic [15:0] ed, rdat;
    int  b, nst;
    bit  st, dn, tmo;
    for (int i = 0; i < NREQ; i++) begin
      key[i] = 16'($urandom);
      ex[i]  = 16'($urandom);
      md[i]  = 16'($urandom) | 16'h0001;
    end
    req_key   = {key[3], key[2], key[1], key[0]};
    req_exp   = {ex[3], ex[2], ex[1], ex[0]};
    req_mod   = {md[3], md[2], md[1], md[0]};
    req_valid = reqv;
    @(negedge clk);
    chk("grant", 64'(req_ready), 64'(4'b0001 << g));
    tick();
    chk("launch_start", 64'(eng_start), 64'd1);
    chk("launch_key", 64'(eng_key), 64'(key[g]));
    chk("launch_exp", 64'(eng_exp), 64'(ex[g]));
    chk("launch_mod", 64'(eng_mod), 64'(md[g]));
    tick();
    ed   = exp_err ? 16'h0 : mexp(key[g], ex[g], md[g]);
    rdat = ok ? mexp(key[g], ex[g], md[g]) : 16'($urandom) | 16'h0001;
    b = 0; nst = 0; tmo = 0;
    forever begin
      b++;
      st = (b >= 3) && (b < 3 + sn);
      dn = (lat != 0) && (b == lat);
      stall      = st;
      eng_done   = dn;
      eng_valid  = ok;
      eng_result = rdat;
      if (!st) nst++;
      tmo = !dn && !st && (nst == TMO);
      @(negedge clk);
      chk("busy_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("busy_abort", 64'(eng_abort), 64'd0);
      chk("busy_eng_stall", 64'(eng_stall), 64'(st));
      if (b == 1) chk("start_one_cycle", 64'(eng_start), 64'd0);
      tick();
      if (dn || tmo) break;
      if (b > 100) begin
        total++; bad++;
        $display("FAIL busy_bound: no completion after %0d cycles", b);
        break;
      end
    end
    stall = 1'b0; eng_done = 1'b0; eng_valid = 1'b0;
    chk("rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rsp_id", 64'(rsp_id), 64'(g));
    chk("rsp_data", 64'(rsp_data), 64'(ed));
    chk("rsp_err", 64'(rsp_err), 64'(exp_err));
    chk("abort_pulse", 64'(eng_abort), 64'(tmo));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_ready", 64'(req_ready), 64'd0);
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_id", 64'(rsp_id), 64'(g));
      chk("hold_data", 64'(rsp_data), 64'(ed));
      chk("hold_err", 64'(rsp_err), 64'(exp_err));
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("hs_no_grant", 64'(req_ready), 64'd0);
    tick();
    rsp_ready = 1'b0;
    req_valid = '0;
    chk("post_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("post_abort", 64'(eng_abort), 64'd0);
  endtask

  typedef struct {
    logic [3:0] reqv;
    int         lat;
    bit         ok;
    int         hold;
    int         sn;
    int         g;
    bit         err;
  } vec_t;

  vec_t tv[12];

  initial begin
    tv[0]  = '{4'b0001, 1,   1'b1, 0,  0, 0, 1'b0};
    tv[1]  = '{4'b1111, 5,   1'b1, 0,  0, 1, 1'b0};
    tv[2]  = '{4'b1111, 5,   1'b1, 0,  0, 2, 1'b0};
    tv[3]  = '{4'b1111, 5,   1'b1, 0,  0, 3, 1'b0};
    tv[4]  = '{4'b1111, 5,   1'b1, 0,  0, 0, 1'b0};
    tv[5]  = '{4'b1111, 5,   1'b1, 10, 0, 1, 1'b0};
    tv[6]  = '{4'b1111, 2,   1'b1, 0,  0, 2, 1'b0};
    tv[7]  = '{4'b0101, 0,   1'b1, 0,  0, 0, 1'b1};
    tv[8]  = '{4'b0110, 0,   1'b1, 2,  8, 1, 1'b1};
    tv[9]  = '{4'b1000, 3,   1'b0, 0,  0, 3, 1'b1};
    tv[10] = '{4'b0011, TMO, 1'b1, 0,  0, 0, 1'b0};
    tv[11] = '{4'b1100, 2,   1'b1, 1,  0, 2, 1'b0};

    rst = 1'b0; stall = 1'b0; rsp_ready = 1'b0;
    eng_done = 1'b0; eng_valid = 1'b0; eng_result = '0;
    req_valid = 4'b0001; req_key = '0; req_exp = '0; req_mod = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_eng_start", 64'(eng_start), 64'd0);
    chk("rst_eng_abort", 64'(eng_abort), 64'd0);
    chk("rst_eng_key", 64'({eng_key, eng_exp, eng_mod}), 64'd0);
    req_valid = '0;
    rst = 1'b1;
    last = NREQ - 1;

    // global stall must block a grant in IDLE
    stall = 1'b1;
    req_valid = 4'b0001;
    @(negedge clk);
    chk("stall_no_grant", 64'(req_ready), 64'd0);
    chk("stall_fwd", 64'(eng_stall), 64'd1);
    tick();
    chk("stall_no_start", 64'(eng_start), 64'd0);
    stall = 1'b0;
    req_valid = '0;

    for (int i = 0; i < 12; i++) begin
      do_txn(tv[i].reqv, tv[i].g, tv[i].lat, tv[i].ok, tv[i].hold, tv[i].sn, tv[i].err);
      last = tv[i].g;
    end

    // asynchronous reset in the middle of BUSY
    req_valid = 4'b0001;
    tick();
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    chk("arst_eng_key", 64'(eng_key), 64'd0);
    chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("arst_req_ready", 64'(req_ready), 64'd0);
    chk("arst_eng_start", 64'(eng_start), 64'd0);
    req_valid = 4'b0100;
    tick();
    tick();
    rst = 1'b1;
    last = NREQ - 1;
    do_txn(4'b0100, 2, 2, 1'b1, 0, 0, 1'b0);
    last = 2;

    for (int n = 0; n < 24; n++) begin
      logic [3:0] rv;
      int g, lat, hold, sn;
      bit ok;
      rv   = 4'($urandom_range(1, 15));
      g    = pick(rv, last);
      lat  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 8));
      ok   = 1'($urandom_range(0, 1));
      hold = $urandom_range(0, 3);
      sn   = $urandom_range(0, 4);
      do_txn(rv, g, lat, ok, hold, sn, (lat == 0) || !ok);
      last = g;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
